seq_divider: RTL and testbench

//   Sequential restoring unsigned divider; the inverse companion of the
//   8-bit pipelined multiplier in the low-power datapath.

---
 rtl/seq_divider.sv | 97 +++++++++
 tb/tb_seq_divider.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock behind a start/busy/done handshake.
// Working registers load only on an accepted start or while calculating, so the datapath is quiet when idle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] r_reg, q_reg, div_reg;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic             trial_ok;
  logic [WIDTH-1:0] r_step, q_step;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    shifted    = {r_reg, q_reg[WIDTH-1]};
    // The true difference is below divisor whenever it is non-negative, so WIDTH bits hold it.
    trial_ok   = (shifted >= {1'b0, div_reg});
    r_step     = trial_ok ? (shifted[WIDTH-1:0] - div_reg) : shifted[WIDTH-1:0];
    q_step     = {q_reg[WIDTH-2:0], trial_ok};
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        last_step = (count == CW'(1));
        if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg       <= '0;
      q_reg       <= '0;
      div_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r_reg   <= '0;
      q_reg   <= dividend;
      div_reg <= divisor;
      count   <= CW'(WIDTH);
      // A zero divisor skips the iteration and publishes its result immediately.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      r_reg <= r_step;
      q_reg <= q_step;
      count <= count - CW'(1);
      if (last_step) begin
        quotient    <= q_step;
        remainder   <= r_step;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake scenarios plus a swept/random scoreboard run.
module tb_seq_divider;

  localparam int WIDTH = 8;
  // Index of the negedge after the accepting edge at which done appears (done follows edge E0+WIDTH).
  localparam int LAT_NORMAL = WIDTH + 1;
  localparam int LAT_ZERO   = 1;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge; returns at the negedge after the accepting edge with operands scrambled.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // Advances negedge by negedge until done is seen or a cycle budget runs out.
  task automatic wait_done(input int first, output int done_cycle, output bit held);
    logic [2*WIDTH:0] snap;
    snap       = {quotient, remainder, div_by_zero};
    held       = 1'b1;
    done_cycle = first;
    while (done !== 1'b1 && done_cycle < 40) begin
      @(negedge clk);
      done_cycle++;
      if (done !== 1'b1 && {quotient, remainder, div_by_zero} !== snap) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    exp_t e;
    int   cyc, busy_cnt, dc;
    bit   held;
    logic [WIDTH-1:0] pa[3] = '{8'd255, 8'd5, 8'd0};
    logic [WIDTH-1:0] pb[3] = '{8'd1, 8'd10, 8'd3};
    logic [WIDTH-1:0] pq[3] = '{8'd255, 8'd0, 8'd0};
    logic [WIDTH-1:0] pr[3] = '{8'd0, 8'd5, 8'd0};

    sb.push_back('{a: 8'd200, b: 8'd7, q: 8'd28, r: 8'd4, dbz: 1'b0});
    start_op(8'd200, 8'd7);
    cyc = 1; busy_cnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (busy_cnt != WIDTH) begin
      n_fail++;
      $display("[TB] FAIL basic_busy_cycles: got %0d, expected %0d", busy_cnt, WIDTH);
    end
    n_checks++;
    if (cyc != LAT_NORMAL) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: got %0d, expected %0d", cyc, LAT_NORMAL);
    end
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("[TB] FAIL basic_result 200/7: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy, quotient, remainder} !== {2'b00, e.q, e.r}) begin
      n_fail++;
      $display("[TB] FAIL basic_pulse: got done=%b busy=%b q=%0d r=%0d, expected done=0 busy=0 q=%0d r=%0d",
               done, busy, quotient, remainder, e.q, e.r);
    end

    for (int i = 0; i < 3; i++) begin
      sb.push_back('{a: pa[i], b: pb[i], q: pq[i], r: pr[i], dbz: 1'b0});
      start_op(pa[i], pb[i]);
      wait_done(1, dc, held);
      e = sb.pop_front();
      n_checks++;
      if ({quotient, remainder, div_by_zero, dc} !== {e.q, e.r, e.dbz, LAT_NORMAL}) begin
        n_fail++;
        $display("[TB] FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=%0d",
                 e.a, e.b, quotient, remainder, div_by_zero, dc, e.q, e.r, e.dbz, LAT_NORMAL);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   dc;
    bit   held;
    sb.push_back('{a: 8'd100, b: 8'd0, q: 8'd255, r: 8'd100, dbz: 1'b1});
    start_op(8'd100, 8'd0);
    wait_done(1, dc, held);
    n_checks++;
    if (dc != LAT_ZERO) begin
      n_fail++;
      $display("[TB] FAIL dbz_latency: got %0d, expected %0d", dc, LAT_ZERO);
    end
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("[TB] FAIL dbz_result: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL dbz_pulse: got done=%b, expected 0", done);
    end

    sb.push_back('{a: 8'd9, b: 8'd3, q: 8'd3, r: 8'd0, dbz: 1'b0});
    start_op(8'd9, 8'd3);
    wait_done(1, dc, held);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero, dc} !== {e.q, e.r, e.dbz, LAT_NORMAL}) begin
      n_fail++;
      $display("[TB] FAIL dbz_clear 9/3: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, dc, e.q, e.r, e.dbz, LAT_NORMAL);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   dc;
    bit   held;
    sb.push_back('{a: 8'd50, b: 8'd5, q: 8'd10, r: 8'd0, dbz: 1'b0});
    start_op(8'd50, 8'd5);
    repeat (2) @(negedge clk);
    dividend = 8'd1; divisor = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, dc, held);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero, dc} !== {e.q, e.r, e.dbz, LAT_NORMAL}) begin
      n_fail++;
      $display("[TB] FAIL busy_ignore 50/5: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, dc, e.q, e.r, e.dbz, LAT_NORMAL);
    end

    sb.push_back('{a: 8'd17, b: 8'd4, q: 8'd4, r: 8'd1, dbz: 1'b0});
    start_op(8'd17, 8'd4);
    n_checks++;
    if ({done, busy} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL b2b_accept: got done=%b busy=%b, expected done=0 busy=1", done, busy);
    end
    wait_done(1, dc, held);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero, dc} !== {e.q, e.r, e.dbz, LAT_NORMAL}) begin
      n_fail++;
      $display("[TB] FAIL b2b_result 17/4: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, dc, e.q, e.r, e.dbz, LAT_NORMAL);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   dc, seen;
    bit   held;
    start_op(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_no_done: got %0d done cycles, expected 0", seen);
    end

    sb.push_back('{a: 8'd13, b: 8'd2, q: 8'd6, r: 8'd1, dbz: 1'b0});
    start_op(8'd13, 8'd2);
    wait_done(1, dc, held);
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero, dc} !== {e.q, e.r, e.dbz, LAT_NORMAL}) begin
      n_fail++;
      $display("[TB] FAIL midreset_next 13/2: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=%0d",
               quotient, remainder, div_by_zero, dc, e.q, e.r, e.dbz, LAT_NORMAL);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    logic [2*WIDTH-1:0] ops[$];
    logic [WIDTH-1:0]   a, b;
    exp_t e, got;
    int   dc, lat;
    bit   held;
    for (int i = 0; i < 256; i++) begin
      ops.push_back({8'd255, 8'(i)});
      ops.push_back({8'(i), 8'd7});
    end
    ops.push_back({8'd0, 8'd0});
    ops.push_back({8'd255, 8'd255});
    for (int i = 0; i < 200; i++) ops.push_back(16'($urandom));

    foreach (ops[k]) begin
      a = ops[k][2*WIDTH-1:WIDTH];
      b = ops[k][WIDTH-1:0];
      if (b == '0) e = '{a: a, b: b, q: '1, r: a, dbz: 1'b1};
      else         e = '{a: a, b: b, q: a / b, r: a % b, dbz: 1'b0};
      sb.push_back(e);
      lat = (b == '0) ? LAT_ZERO : LAT_NORMAL;
      start_op(a, b);
      wait_done(1, dc, held);
      n_checks++;
      if (dc != lat) begin
        n_fail++;
        $display("[TB] FAIL sweep_latency %0d/%0d: got %0d, expected %0d", a, b, dc, lat);
      end
      n_checks++;
      if (held !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL sweep_hold %0d/%0d: got outputs changed before done, expected held", a, b);
      end
      got = sb.pop_front();
      n_checks++;
      if ({quotient, remainder, div_by_zero} !== {got.q, got.r, got.dbz}) begin
        n_fail++;
        $display("[TB] FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
                 a, b, quotient, remainder, div_by_zero, got.q, got.r, got.dbz);
      end
      if (b != '0) begin
        n_checks++;
        if (!((int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b))) begin
          n_fail++;
          $display("[TB] FAIL sweep_invariant %0d/%0d: got q=%0d r=%0d, expected q*d+r==n and r<d",
                   a, b, quotient, remainder);
        end
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL sweep_pulse %0d/%0d: got done=%b, expected 0", a, b, done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
